fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 28 ++
 rtl/fetch_stage_fd_skid_reg.sv | 65 ++++++
 rtl/fetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants, FSM encoding and F/D payload type for the fetch stage.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] PC_RESET = 32'h0000_3000;
    localparam logic [XLEN-1:0] TEXT_LO  = 32'h0000_3000;
    localparam logic [XLEN-1:0] TEXT_HI  = 32'h0000_6FFC;
    localparam logic [XLEN-1:0] NOP      = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            adel;
    } fd_entry_t;

    // Word-aligned and inside the text segment.
    function automatic logic pc_legal(input logic [XLEN-1:0] pc);
        return (pc[1:0] == 2'b00) && (pc >= TEXT_LO) && (pc <= TEXT_HI);
    endfunction

endpackage

// File: rtl/fetch_stage_fd_skid_reg.sv
// F/D pipeline register with a one-entry skid buffer that catches a fetch
// completing while D is stalled.
module fd_skid_reg
    import fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_new_i,
    input  logic            stash_i,
    input  logic            load_buf_i,
    input  logic            bubble_i,
    input  logic [XLEN-1:0] new_instr_i,
    input  logic [XLEN-1:0] new_pc_i,
    input  logic            new_adel_i,
    output logic [XLEN-1:0] fd_instr_o,
    output logic [XLEN-1:0] fd_pc_o,
    output logic            fd_adel_o,
    output logic            fd_valid_o
);

    fd_entry_t new_c;
    fd_entry_t fd_q, fd_d;
    fd_entry_t buf_q, buf_d;
    logic      valid_q, valid_d;

    assign new_c = fd_entry_t'{instr: new_instr_i, pc: new_pc_i, adel: new_adel_i};

    always_comb begin
        fd_d    = fd_q;
        valid_d = valid_q;
        buf_d   = buf_q;
        if (load_new_i) begin
            fd_d    = new_c;
            valid_d = 1'b1;
        end else if (load_buf_i) begin
            fd_d    = buf_q;
            valid_d = 1'b1;
            buf_d   = '0;
        end else if (stash_i) begin
            buf_d = new_c;
        end else if (bubble_i) begin
            // Bubble keeps the last PC so F_D_PC never jumps backwards.
            fd_d    = fd_entry_t'{instr: NOP, pc: fd_q.pc, adel: 1'b0};
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fd_q    <= '0;
            buf_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            fd_q    <= fd_d;
            buf_q   <= buf_d;
            valid_q <= valid_d;
        end
    end

    assign fd_instr_o = fd_q.instr;
    assign fd_pc_o    = fd_q.pc;
    assign fd_adel_o  = fd_q.adel;
    assign fd_valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, delayed-branch redirect and IM
// request FSM feeding the F/D skid register.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            D_Stall,
    input  logic            D_NPC_Sel,
    input  logic [XLEN-1:0] D_NPC_NPC,
    output logic            F_IM_Req,
    output logic [XLEN-1:0] F_IM_Addr,
    input  logic            F_IM_Ready,
    input  logic [XLEN-1:0] F_IM_Rdata,
    output logic [XLEN-1:0] F_PC,
    output logic [XLEN-1:0] F_D_Instr,
    output logic [XLEN-1:0] F_D_PC,
    output logic            F_D_Valid,
    output logic            F_D_ExcAdEL
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            pending_q, pending_d;

    logic            legal_c;
    logic            complete_c;
    logic            capture_c;
    logic [XLEN-1:0] npc_c;
    logic            advance_c;
    logic            load_new_c, stash_c, load_buf_c, bubble_c;

    assign legal_c    = pc_legal(pc_q);
    // An illegal PC completes at once without touching instruction memory.
    assign complete_c = (state_q == S_WAIT) && (!legal_c || F_IM_Ready);
    assign capture_c  = D_NPC_Sel && F_D_Valid && !D_Stall;
    assign npc_c      = capture_c ? D_NPC_NPC : (pending_q ? target_q : pc_q + XLEN'(4));

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pending_d  = pending_q;
        target_d   = target_q;
        advance_c  = 1'b0;
        load_new_c = 1'b0;
        stash_c    = 1'b0;
        load_buf_c = 1'b0;
        bubble_c   = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_WAIT;
            S_WAIT: begin
                if (complete_c) begin
                    if (!D_Stall) begin
                        load_new_c = 1'b1;
                        advance_c  = 1'b1;
                    end else begin
                        stash_c = 1'b1;
                        state_d = S_FULL;
                    end
                end else if (!D_Stall) begin
                    bubble_c = 1'b1;
                end
            end
            S_FULL: begin
                if (!D_Stall) begin
                    load_buf_c = 1'b1;
                    advance_c  = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Consuming next-PC wins over a same-edge capture; npc_c already holds it.
        if (advance_c) begin
            pc_d      = npc_c;
            pending_d = 1'b0;
        end else if (capture_c) begin
            pending_d = 1'b1;
            target_d  = D_NPC_NPC;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= PC_RESET;
            pending_q <= 1'b0;
            target_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            target_q  <= target_d;
        end
    end

    fd_skid_reg u_fd_skid_reg (
        .clk        (clk),
        .rst_n      (reset),
        .load_new_i (load_new_c),
        .stash_i    (stash_c),
        .load_buf_i (load_buf_c),
        .bubble_i   (bubble_c),
        .new_instr_i(legal_c ? F_IM_Rdata : NOP),
        .new_pc_i   (pc_q),
        .new_adel_i (!legal_c),
        .fd_instr_o (F_D_Instr),
        .fd_pc_o    (F_D_PC),
        .fd_adel_o  (F_D_ExcAdEL),
        .fd_valid_o (F_D_Valid)
    );

    assign F_IM_Req  = (state_q == S_WAIT) && legal_c;
    assign F_IM_Addr = pc_q;
    assign F_PC      = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected F/D
// entries; a monitor pops them as D consumes each valid instruction.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        D_Stall = 1'b0;
    logic        D_NPC_Sel;
    logic [31:0] D_NPC_NPC;
    logic        F_IM_Req;
    logic [31:0] F_IM_Addr;
    logic        F_IM_Ready;
    logic [31:0] F_IM_Rdata;
    logic [31:0] F_PC;
    logic [31:0] F_D_Instr;
    logic [31:0] F_D_PC;
    logic        F_D_Valid;
    logic        F_D_ExcAdEL;

    int unsigned im_delay = 0;
    int unsigned wait_cnt = 0;
    logic        jump_en  = 1'b0;
    logic [31:0] jump_pc  = 32'h0;
    logic [31:0] jump_tgt = 32'h0;

    int checks = 0;
    int errors = 0;
    fd_entry_t sb_q[$];

    logic [31:0] rd_tgt  [4] = '{32'h0000_3002, 32'h0000_7000, 32'h0000_6FFC, 32'h0000_2FFC};
    logic        rd_adel0[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic        rd_adel1[4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .D_Stall    (D_Stall),
        .D_NPC_Sel  (D_NPC_Sel),
        .D_NPC_NPC  (D_NPC_NPC),
        .F_IM_Req   (F_IM_Req),
        .F_IM_Addr  (F_IM_Addr),
        .F_IM_Ready (F_IM_Ready),
        .F_IM_Rdata (F_IM_Rdata),
        .F_PC       (F_PC),
        .F_D_Instr  (F_D_Instr),
        .F_D_PC     (F_D_PC),
        .F_D_Valid  (F_D_Valid),
        .F_D_ExcAdEL(F_D_ExcAdEL)
    );

    always #5 clk = ~clk;

    // Instruction memory: word = 0xC0000000 | address, ready after im_delay waiting cycles.
    assign F_IM_Ready = F_IM_Req && (wait_cnt >= im_delay);
    assign F_IM_Rdata = 32'hC000_0000 | F_IM_Addr;
    always @(posedge clk) begin
        if (F_IM_Req && !F_IM_Ready) wait_cnt <= wait_cnt + 1;
        else                         wait_cnt <= 0;
    end

    // D stage: a jump sits at jump_pc.
    assign D_NPC_Sel = jump_en && F_D_Valid && (F_D_PC == jump_pc);
    assign D_NPC_NPC = jump_tgt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void exp_push(input logic [31:0] pc, input logic adel);
        fd_entry_t e;
        e.pc    = pc;
        e.adel  = adel;
        e.instr = adel ? 32'h0 : (32'hC000_0000 | pc);
        sb_q.push_back(e);
    endfunction

    function automatic void exp_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_push(start + 32'(4 * i), 1'b0);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Asserts reset, checks the forced values, releases 2 cycles later (#2 after an edge).
    task automatic apply_reset();
        reset = 1'b0;
        #1;
        chk("rst_f_pc",  F_PC, 32'h0000_3000);
        chk("rst_req",   32'(F_IM_Req), 32'h0);
        chk("rst_instr", F_D_Instr, 32'h0);
        chk("rst_fd_pc", F_D_PC, 32'h0);
        chk("rst_valid", 32'(F_D_Valid), 32'h0);
        chk("rst_adel",  32'(F_D_ExcAdEL), 32'h0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic chk_drain(input string name);
        chk(name, 32'(sb_q.size()), 32'h0);
        sb_q.delete();
    endtask

    // Monitor: D consumes the F/D entry on any edge where it is valid and not stalled.
    always @(negedge clk) begin : monitor
        fd_entry_t e;
        if (reset && F_D_Valid && !D_Stall && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_instr", F_D_Instr, e.instr);
            chk("sb_pc",    F_D_PC,    e.pc);
            chk("sb_adel",  32'(F_D_ExcAdEL), 32'(e.adel));
        end
    end

    initial begin
        #1;
        // Straight-line fetch, IM always ready.
        im_delay = 0;
        apply_reset();
        exp_seq(32'h3000, 3);
        step(1);
        chk("seq_req",    32'(F_IM_Req), 32'h1);
        chk("seq_addr0",  F_IM_Addr, 32'h3000);
        step(1);
        chk("seq_addr1",  F_IM_Addr, 32'h3004);
        chk("seq_fd_pc0", F_D_PC, 32'h3000);
        chk("seq_valid0", 32'(F_D_Valid), 32'h1);
        step(1);
        chk("seq_addr2",  F_IM_Addr, 32'h3008);
        step(3);
        chk_drain("seq_drain");

        // Slow IM: two bubbles, then the first word.
        im_delay = 2;
        apply_reset();
        exp_seq(32'h3000, 1);
        step(1);
        chk("slow_req",    32'(F_IM_Req), 32'h1);
        chk("slow_valid0", 32'(F_D_Valid), 32'h0);
        for (int b = 0; b < 2; b++) begin
            step(1);
            chk("bubble_valid", 32'(F_D_Valid), 32'h0);
            chk("bubble_instr", F_D_Instr, 32'h0);
        end
        step(1);
        chk("slow_valid", 32'(F_D_Valid), 32'h1);
        chk("slow_instr", F_D_Instr, 32'hC000_3000);
        chk("slow_pc",    F_D_PC, 32'h3000);
        step(2);
        chk_drain("slow_drain");

        // Jump at 0x3010 to 0x3400, with fast IM and with one-cycle IM latency.
        for (int d = 0; d < 2; d++) begin
            im_delay = d;
            jump_en  = 1'b1;
            jump_pc  = 32'h3010;
            jump_tgt = 32'h3400;
            apply_reset();
            exp_seq(32'h3000, 6);
            exp_seq(32'h3400, 3);
            if (d == 0) begin
                step(7);
                chk("jmp_addr",  F_IM_Addr, 32'h3400);
                chk("jmp_slot",  F_D_PC, 32'h3014);
                step(5);
            end else begin
                step(12);
                chk("jmp_hold_addr", F_IM_Addr, 32'h3014);
                chk("jmp_hold_vld",  32'(F_D_Valid), 32'h0);
                step(1);
                chk("jmp_pend_addr", F_IM_Addr, 32'h3400);
                chk("jmp_pend_slot", F_D_PC, 32'h3014);
                step(8);
            end
            chk_drain("jmp_drain");
        end
        jump_en = 1'b0;

        // D stall for 4 cycles while IM is ready.
        im_delay = 0;
        apply_reset();
        exp_seq(32'h3000, 4);
        step(3);
        D_Stall = 1'b1;
        step(1);
        chk("stall_req",   32'(F_IM_Req), 32'h0);
        chk("stall_addr",  F_IM_Addr, 32'h3008);
        chk("stall_fd_pc", F_D_PC, 32'h3004);
        chk("stall_valid", 32'(F_D_Valid), 32'h1);
        step(2);
        chk("stall_req2",  32'(F_IM_Req), 32'h0);
        chk("stall_hold",  F_D_PC, 32'h3004);
        step(1);
        D_Stall = 1'b0;
        step(1);
        chk("unstall_fd_pc", F_D_PC, 32'h3008);
        chk("unstall_instr", F_D_Instr, 32'hC000_3008);
        chk("unstall_addr",  F_IM_Addr, 32'h300C);
        chk("unstall_req",   32'(F_IM_Req), 32'h1);
        step(1);
        chk("unstall_next",  F_D_PC, 32'h300C);
        step(2);
        chk_drain("stall_drain");

        // Redirects to misaligned, above, at and below the text boundaries.
        for (int i = 0; i < 4; i++) begin
            im_delay = 0;
            jump_en  = 1'b1;
            jump_pc  = 32'h3008;
            jump_tgt = rd_tgt[i];
            apply_reset();
            exp_seq(32'h3000, 4);
            exp_push(rd_tgt[i], rd_adel0[i]);
            exp_push(rd_tgt[i] + 32'h4, rd_adel1[i]);
            step(5);
            chk("rd_addr", F_IM_Addr, rd_tgt[i]);
            chk("rd_req",  32'(F_IM_Req), 32'(!rd_adel0[i]));
            step(1);
            chk("rd_fd_pc", F_D_PC, rd_tgt[i]);
            chk("rd_adel",  32'(F_D_ExcAdEL), 32'(rd_adel0[i]));
            chk("rd_valid", 32'(F_D_Valid), 32'h1);
            chk("rd_instr", F_D_Instr, rd_adel0[i] ? 32'h0 : (32'hC000_0000 | rd_tgt[i]));
            step(2);
            chk_drain("rd_drain");
        end
        jump_en = 1'b0;

        // Reset mid-WAIT while the IM response is being returned.
        im_delay = 2;
        apply_reset();
        exp_seq(32'h3000, 1);
        step(6);
        #1;
        chk("mid_req_live", 32'(F_IM_Req), 32'h1);
        chk_drain("mid_drain");
        im_delay = 0;
        apply_reset();
        exp_seq(32'h3000, 2);
        step(1);
        chk("post_rst_addr", F_IM_Addr, 32'h3000);
        chk("post_rst_req",  32'(F_IM_Req), 32'h1);
        step(3);
        chk_drain("post_rst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
